// File: rtl/vn_collector_pkg.sv
// Shared constants and types for the VN result collector.
package vn_collector_pkg;

  localparam int DATA_TYPE = 32;            // one FP32 result word
  localparam int NUM_AS    = 8;             // adder switches feeding one collector
  localparam int NUM_SLOTS = 2 * NUM_AS;    // two VN words per switch
  localparam int SLOT_BITS = 4;             // log2(NUM_SLOTS)
  localparam int VEC_DEPTH = 4;             // FIFO depth in vectors (power of 2)
  localparam int PTR_BITS  = 2;             // log2(VEC_DEPTH)

  // Slot mapping: switch k drives slot 2k (right VN) and slot 2k+1 (left VN).
  localparam int SLOT_RIGHT_OFS = 0;
  localparam int SLOT_LEFT_OFS  = 1;

  typedef logic [SLOT_BITS-1:0]           slot_t;
  typedef logic [NUM_SLOTS-1:0]           mask_t;
  typedef logic [DATA_TYPE-1:0]           word_t;
  typedef logic [NUM_SLOTS*DATA_TYPE-1:0] vec_t;
  typedef logic [PTR_BITS:0]              ptr_t;   // extra MSB separates full from empty

endpackage

// File: rtl/vn_collector_lowest_set_encoder.sv
// Priority encoder: index of the lowest set bit of a mask, plus an any-set flag.
module lowest_set_encoder #(
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_BITS = 4
) (
  input  logic [NUM_SLOTS-1:0] mask_i,
  output logic [SLOT_BITS-1:0] index_o,
  output logic                 any_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    index_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      index_o = mask_i[i] ? SLOT_BITS'(i) : index_o;
    end
    any_o = |mask_i;
  end

endmodule

// File: rtl/vn_collector.sv
// Collects per-switch VN word vectors into a small FIFO and serializes the
// valid words, lowest slot first, onto a valid/ready stream. Overrun is
// flagged (sticky) because the adder switches cannot be stalled.
module vn_collector
  import vn_collector_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SLOTS*DATA_TYPE-1:0] i_vn,
  input  logic [NUM_SLOTS-1:0]           i_vn_valid,
  input  logic                           i_clear,
  output logic [DATA_TYPE-1:0]           o_data,
  output logic [SLOT_BITS-1:0]           o_slot,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_overflow,
  output logic                           o_busy,
  output logic [15:0]                    o_word_cnt
);

  vec_t  data_q [VEC_DEPTH];
  mask_t mask_q [VEC_DEPTH];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  logic  overflow_q, overflow_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic [PTR_BITS-1:0] wr_idx_s, rd_idx_s;
  logic  empty_s, full_s;
  mask_t head_mask_s, onehot_s, rest_mask_s;
  vec_t  head_data_s;
  slot_t head_slot_s;
  logic  head_any_s;
  logic  hs_s, pop_s, push_req_s, push_s, drop_s;

  assign wr_idx_s = wr_ptr_q[PTR_BITS-1:0];
  assign rd_idx_s = rd_ptr_q[PTR_BITS-1:0];
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) && (wr_idx_s == rd_idx_s);

  // Stale masks may linger in freed entries after a clear, so gate on empty.
  assign head_mask_s = empty_s ? '0 : mask_q[rd_idx_s];
  assign head_data_s = data_q[rd_idx_s];

  lowest_set_encoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_BITS (SLOT_BITS)
  ) u_enc (
    .mask_i  (head_mask_s),
    .index_o (head_slot_s),
    .any_o   (head_any_s)
  );

  assign onehot_s    = mask_t'(1'b1) << head_slot_s;
  assign rest_mask_s = head_mask_s & ~onehot_s;
  assign hs_s        = head_any_s & i_ready;
  assign pop_s       = hs_s & (rest_mask_s == '0);
  assign push_req_s  = |i_vn_valid;
  // A full FIFO still accepts when the head retires in the same cycle.
  assign push_s      = push_req_s & (~full_s | pop_s);
  assign drop_s      = push_req_s & full_s & ~pop_s;

  assign o_valid    = head_any_s;
  assign o_busy     = ~empty_s;
  assign o_slot     = head_slot_s;
  assign o_data     = empty_s ? '0 : head_data_s[head_slot_s*DATA_TYPE +: DATA_TYPE];
  assign o_overflow = overflow_q;
  assign o_word_cnt = word_cnt_q;

  // Next-state for pointers, word counter and overflow flag; clear wins.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q;
    if (i_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      word_cnt_d = 16'd0;
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d   = push_s ? (wr_ptr_q + ptr_t'(1)) : wr_ptr_q;
      rd_ptr_d   = pop_s  ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;
      word_cnt_d = hs_s   ? (word_cnt_q + 16'd1)   : word_cnt_q;
      overflow_d = overflow_q | drop_s;
    end
  end

  // Control state and per-entry masks; push write comes last so it wins
  // when a full FIFO pops and refills the same entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_cnt_q <= 16'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < VEC_DEPTH; i++) begin
        mask_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_cnt_q <= word_cnt_d;
      overflow_q <= overflow_d;
      if (!i_clear) begin
        if (hs_s) begin
          mask_q[rd_idx_s] <= rest_mask_s;
        end
        if (push_s) begin
          mask_q[wr_idx_s] <= i_vn_valid;
        end
      end
    end
  end

  // Data payload storage; contents are only meaningful under a live mask.
  always_ff @(posedge clk) begin
    if (push_s && !i_clear) begin
      data_q[wr_idx_s] <= i_vn;
    end
  end

endmodule

// File: tb/tb_vn_collector.sv
// Directed scoreboard bench for vn_collector.
module tb_vn_collector;
  import vn_collector_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_SLOTS*DATA_TYPE-1:0] i_vn;
  logic [NUM_SLOTS-1:0]           i_vn_valid;
  logic                           i_clear;
  logic                           i_ready;
  logic [DATA_TYPE-1:0]           o_data;
  logic [SLOT_BITS-1:0]           o_slot;
  logic                           o_valid;
  logic                           o_overflow;
  logic                           o_busy;
  logic [15:0]                    o_word_cnt;

  typedef struct packed {
    logic [3:0]  slot;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  vn_collector dut (
    .clk        (clk),
    .rst        (rst),
    .i_vn       (i_vn),
    .i_vn_valid (i_vn_valid),
    .i_clear    (i_clear),
    .o_data     (o_data),
    .o_slot     (o_slot),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_word_cnt (o_word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_SLOTS*DATA_TYPE-1:0] mk_vec(input logic [31:0] base);
    logic [NUM_SLOTS*DATA_TYPE-1:0] v;
    for (int s = 0; s < NUM_SLOTS; s++) v[s*DATA_TYPE +: DATA_TYPE] = base + 32'(s);
    return v;
  endfunction

  // Drive one vector for the coming edge; optionally record the words it must produce.
  task automatic send(input logic [15:0] m, input logic [NUM_SLOTS*DATA_TYPE-1:0] v,
                      input bit expect_out);
    @(posedge clk); #1;
    i_vn       = v;
    i_vn_valid = m;
    i_clear    = 1'b0;
    if (expect_out) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (m[s]) sb.push_back({4'(s), v[s*DATA_TYPE +: DATA_TYPE]});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_vn_valid = '0;
      i_clear    = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200; k++) begin
      if (!o_busy) break;
      idle(1);
    end
    chk("drain_done_busy", {31'd0, o_busy}, 32'd0);
  endtask

  // Monitor: every accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1 && i_clear === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got slot %0d data %h expected no word", o_slot, o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_slot", {28'd0, o_slot}, {28'd0, e.slot});
        chk("mon_data", o_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [NUM_SLOTS*DATA_TYPE-1:0] v;
    rst        = 1'b0;
    i_vn       = '0;
    i_vn_valid = '0;
    i_clear    = 1'b0;
    i_ready    = 1'b1;
    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_slot", {28'd0, o_slot}, 32'd0);
    chk("rst_cnt", {16'd0, o_word_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single vector, slots 0 and 2
    v = '0;
    v[0*32 +: 32] = 32'h3F800000;
    v[2*32 +: 32] = 32'h40000000;
    send(16'h0005, v, 1'b1);
    idle(1);
    chk("t1_latency_valid", {31'd0, o_valid}, 32'd1);
    chk("t1_first_slot", {28'd0, o_slot}, 32'd0);
    idle(2);
    chk("t1_cnt", {16'd0, o_word_cnt}, 32'd2);
    chk("t1_busy", {31'd0, o_busy}, 32'd0);

    // Backpressure with slot 3 pending
    i_ready = 1'b0;
    send(16'h0008, mk_vec(32'hDEAD0000), 1'b1);
    for (int c = 0; c < 5; c++) begin
      idle(1);
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_slot", {28'd0, o_slot}, 32'd3);
      chk("bp_data", o_data, 32'hDEAD0003);
    end
    i_ready = 1'b1;
    idle(2);
    chk("bp_cnt", {16'd0, o_word_cnt}, 32'd3);
    chk("bp_busy", {31'd0, o_busy}, 32'd0);

    // Overflow: five vectors into a four-deep FIFO
    i_ready = 1'b0;
    send(16'h0001, mk_vec(32'h00001000), 1'b1);
    send(16'h0006, mk_vec(32'h00002000), 1'b1);
    send(16'h8000, mk_vec(32'h00003000), 1'b1);
    send(16'h0410, mk_vec(32'h00004000), 1'b1);
    send(16'h0003, mk_vec(32'h00005000), 1'b0);
    idle(1);
    chk("ovf_set", {31'd0, o_overflow}, 32'd1);
    chk("ovf_busy", {31'd0, o_busy}, 32'd1);
    i_ready = 1'b1;
    wait_drain();
    chk("ovf_sb_empty", sb.size(), 32'd0);
    chk("ovf_cnt", {16'd0, o_word_cnt}, 32'd9);
    chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
    @(posedge clk); #1;
    i_clear = 1'b1;
    idle(1);
    chk("clr_ovf", {31'd0, o_overflow}, 32'd0);
    chk("clr_cnt", {16'd0, o_word_cnt}, 32'd0);

    // Full FIFO, last head bit retiring while a new vector arrives
    i_ready = 1'b0;
    send(16'h0001, mk_vec(32'h00000100), 1'b1);
    send(16'h0002, mk_vec(32'h00000200), 1'b1);
    send(16'h0004, mk_vec(32'h00000300), 1'b1);
    send(16'h0008, mk_vec(32'h00000400), 1'b1);
    send(16'h0010, mk_vec(32'h00000500), 1'b1);
    i_ready = 1'b1;
    idle(1);
    chk("fp_ovf", {31'd0, o_overflow}, 32'd0);
    wait_drain();
    chk("fp_cnt", {16'd0, o_word_cnt}, 32'd5);
    chk("fp_sb_empty", sb.size(), 32'd0);
    chk("fp_ovf_end", {31'd0, o_overflow}, 32'd0);

    // Clear beats enqueue and handshake in the same cycle
    i_ready = 1'b0;
    send(16'h0003, mk_vec(32'h00000600), 1'b0);
    @(posedge clk); #1;
    i_vn       = mk_vec(32'h00000700);
    i_vn_valid = 16'h0100;
    i_ready    = 1'b1;
    i_clear    = 1'b1;
    idle(1);
    chk("cp_busy", {31'd0, o_busy}, 32'd0);
    chk("cp_cnt", {16'd0, o_word_cnt}, 32'd0);
    chk("cp_ovf", {31'd0, o_overflow}, 32'd0);
    chk("cp_valid", {31'd0, o_valid}, 32'd0);
    idle(3);
    chk("cp_no_emit_cnt", {16'd0, o_word_cnt}, 32'd0);

    // Asynchronous reset in the middle of a drain
    i_ready = 1'b0;
    send(16'h00FF, mk_vec(32'h00000800), 1'b0);
    idle(1);
    i_ready = 1'b1;
    sb.push_back({4'd0, 32'h00000800});
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("ar_cnt_before", {16'd0, o_word_cnt}, 32'd1);
    chk("ar_valid_before", {31'd0, o_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", {31'd0, o_valid}, 32'd0);
    chk("ar_cnt", {16'd0, o_word_cnt}, 32'd0);
    chk("ar_busy", {31'd0, o_busy}, 32'd0);
    chk("ar_data", o_data, 32'd0);
    #3;
    rst = 1'b1;
    i_ready = 1'b1;
    idle(3);
    chk("ar_busy_after", {31'd0, o_busy}, 32'd0);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vn_collector.md
Name: vn_collector

Overview:
- Sink for the virtual-neuron (VN) result outputs of one level of adder switches in the reduction network.
- Every cycle it captures the per-switch VN word pairs and their valid bits as one vector.
- It buffers these vectors in a small FIFO and serializes the valid words, lowest slot first, onto a single valid/ready stream toward the output buffer.
- Adder switches cannot be stalled, so FIFO overrun is flagged rather than back-pressured.

Parameters:
- DATA_TYPE, 32, width of one result word (FP32).
- NUM_AS, 8, number of adder switches feeding the collector.
- NUM_SLOTS, 2*NUM_AS, number of VN word slots per vector.
- SLOT_BITS, 4, log2(NUM_SLOTS).
- VEC_DEPTH, 4, FIFO depth in vectors; must be a power of 2.
- PTR_BITS, 2, log2(VEC_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- i_vn  in  NUM_SLOTS*DATA_TYPE  concatenated switch VN buses; switch k occupies bits [2k*DATA_TYPE +: 2*DATA_TYPE].
- i_vn_valid  in  NUM_SLOTS  concatenated switch VN valid pairs; switch k occupies bits [2k +: 2].
- i_clear  in  1  synchronous flush.
- o_data  out  DATA_TYPE  serialized result word.
- o_slot  out  SLOT_BITS  slot index of o_data.
- o_valid  out  1  o_data/o_slot valid.
- i_ready  in  1  downstream accepts.
- o_overflow  out  1  sticky: a vector was dropped.
- o_busy  out  1  FIFO non-empty.
- o_word_cnt  out  16  words emitted since reset/clear; wraps at 2^16.

Behaviour:
- Slot mapping: slot s = i_vn[s*DATA_TYPE +: DATA_TYPE], valid = i_vn_valid[s]. So slot 2k is switch k's right VN and slot 2k+1 is its left VN.
- Reset (rst=0, async): FIFO empty, pointers 0, o_overflow=0, o_word_cnt=0. Consequently o_valid=0, o_busy=0, o_data=0, o_slot=0.
- Enqueue at a clk edge when i_vn_valid != 0:
  - The whole data vector and its mask are written.
  - All-zero masks are never stored.
- Full handling: if the FIFO is full and no pop occurs that cycle, the vector is dropped and o_overflow is set (sticky). If a pop occurs that same cycle, the vector is accepted.
- Serializer works on the head entry only:
  - o_valid = o_busy.
  - o_slot = index of the lowest set bit of the head mask.
  - o_data = head data[o_slot]; o_data and o_slot are 0 when empty.
  - All outputs are driven from registers or a combinational decode of the registered head. There is no input-to-output combinational path.
- Handshake (o_valid & i_ready at an edge):
  - Clear head mask bit o_slot and increment o_word_cnt.
  - If that was the last set bit, pop the entry.
  - o_data and o_slot must hold stable while o_valid=1 and i_ready=0.
- Latency: a vector enqueued at edge N gives o_valid=1 after edge N, provided the FIFO was empty. A vector with m valid bits drains in m accepted cycles.
- Ordering: vectors leave in arrival order; words within a vector leave in ascending slot order.
- Simultaneous enqueue and pop with the FIFO not full: both happen and the count is unchanged.
- Pointers wrap modulo VEC_DEPTH; full/empty are tracked by an extra pointer MSB.
- i_clear=1 at an edge:
  - Empties the FIFO and zeroes o_word_cnt and o_overflow.
  - Has priority over enqueue and handshake in that cycle; the incoming vector is discarded.
- Reset asserted mid-drain: all state returns to reset values immediately, and pending words are lost.

Decomposition:
- Shared package constants: DATA_TYPE, and the slot-mapping convention as localparam offsets.
- The pure combinational sub-module is lowest_set_encoder (parameters NUM_SLOTS and SLOT_BITS; mask in, index and any-set out). It is reusable by other collectors.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset then single vector: i_vn_valid=16'h0005, slot0=0x3F800000, slot2=0x40000000, i_ready=1 -> words (slot 0, 0x3F800000) then (slot 2, 0x40000000) on consecutive cycles; o_word_cnt=2; o_busy=0 afterward.
- Backpressure: i_ready=0 for 5 cycles with head slot 3 pending -> o_valid=1 and o_data/o_slot unchanged throughout; one word counted after i_ready=1.
- Overflow: i_ready=0, enqueue 5 nonzero vectors -> first 4 stored, o_overflow=1 after the 5th; draining yields only the 4 stored vectors, in order.
- Full plus pop same cycle: FIFO full, head has 1 bit left, i_ready=1, new vector arrives -> accepted, o_overflow stays 0.
- Clear priority: i_clear=1 together with a new vector and a handshake -> o_busy=0, o_word_cnt=0, o_overflow=0 next cycle; the vector is not emitted.
- Async reset mid-drain: rst low between edges -> o_valid=0 and o_word_cnt=0 immediately, without waiting for clk.
